// File: rtl/dmem_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the data-memory arbiter.
// slave is the arbiter's view; master is the view of whatever drives the cores and memory.
interface dmem_arbiter_if #(
   parameter int num_req_p = 4
);
   logic [num_req_p-1:0]    req_valid_i;
   logic [num_req_p-1:0]    req_wen_i;
   logic [num_req_p-1:0]    req_byte_i;
   logic [32*num_req_p-1:0] req_addr_i;
   logic [32*num_req_p-1:0] req_wdata_i;
   logic [num_req_p-1:0]    req_yumi_o;
   logic [num_req_p-1:0]    resp_valid_o;
   logic [31:0]             resp_data_o;
   logic [num_req_p-1:0]    resp_yumi_i;
   logic                    mem_valid_o;
   logic                    mem_wen_o;
   logic                    mem_byte_o;
   logic [31:0]             mem_addr_o;
   logic [31:0]             mem_wdata_o;
   logic                    mem_yumi_i;
   logic                    mem_resp_valid_i;
   logic [31:0]             mem_rdata_i;
   logic                    mem_resp_yumi_o;
   logic [2:0]              owner_o;
   logic                    busy_o;
   logic                    timeout_o;

   modport slave (
      input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
      input  mem_yumi_i, mem_resp_valid_i, mem_rdata_i,
      output req_yumi_o, resp_valid_o, resp_data_o,
      output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_resp_yumi_o,
      output owner_o, busy_o, timeout_o
   );

   modport master (
      output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, resp_yumi_i,
      output mem_yumi_i, mem_resp_valid_i, mem_rdata_i,
      input  req_yumi_o, resp_valid_o, resp_data_o,
      input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_resp_yumi_o,
      input  owner_o, busy_o, timeout_o
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among num_req_p cores.
// One transaction in flight: IDLE picks a winner and latches its request,
// ISSUE presents it to memory, RESP forwards the response to the owner.
// A sticky flag reports transactions that stay busy for timeout_p cycles.
module dmem_arbiter #(
   parameter int num_req_p = 4,
   parameter int timeout_p = 255
) (
   input logic            clk,
   input logic            reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_issue = 2'd1,
      st_resp  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  owner_reg, owner_next;
   logic [2:0]  rr_ptr_reg, rr_ptr_next;
   logic        wen_reg, byte_reg;
   logic [31:0] addr_reg, wdata_reg;
   logic [7:0]  cnt_reg;
   logic        timeout_reg;

   // Requester inputs widened to 8 lanes so a 3-bit index always fits exactly.
   logic [7:0]  valid8, wen8, byte8, resp_yumi8;
   logic [31:0] core_addr  [8];
   logic [31:0] core_wdata [8];

   logic        grant_found;
   logic [2:0]  grant_idx;
   logic [3:0]  scan_idx;
   logic        latch_en;
   logic        mem_valid_c, yumi_fire_c, resp_show_c, resp_fire_c;
   logic [8:0]  cnt_inc;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         if (gi < num_req_p) begin : g_live
            assign valid8[gi]     = bus.req_valid_i[gi];
            assign wen8[gi]       = bus.req_wen_i[gi];
            assign byte8[gi]      = bus.req_byte_i[gi];
            assign resp_yumi8[gi] = bus.resp_yumi_i[gi];
            assign core_addr[gi]  = bus.req_addr_i[32*gi +: 32];
            assign core_wdata[gi] = bus.req_wdata_i[32*gi +: 32];
         end else begin : g_dead
            assign valid8[gi]     = 1'b0;
            assign wen8[gi]       = 1'b0;
            assign byte8[gi]      = 1'b0;
            assign resp_yumi8[gi] = 1'b0;
            assign core_addr[gi]  = 32'd0;
            assign core_wdata[gi] = 32'd0;
         end
      end
   endgenerate

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = 3'd0;
      scan_idx    = 4'd0;
      for (int i = 0; i < num_req_p; i++) begin
         scan_idx = {1'b0, rr_ptr_reg} + 4'(i);
         if (scan_idx >= 4'(num_req_p)) begin
            scan_idx = scan_idx - 4'(num_req_p);
         end
         if (!grant_found && valid8[scan_idx[2:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[2:0];
         end
      end
   end

   // Next-state and handshake decode; all handshakes are suppressed while reset is low.
   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      latch_en    = 1'b0;
      mem_valid_c = 1'b0;
      yumi_fire_c = 1'b0;
      resp_show_c = 1'b0;
      resp_fire_c = 1'b0;
      case (state_reg)
         st_idle: begin
            if (grant_found) begin
               owner_next = grant_idx;
               latch_en   = 1'b1;
               state_next = st_issue;
            end
         end
         st_issue: begin
            mem_valid_c = 1'b1;
            // A response arriving together with the accept is left for RESP to take.
            if (bus.mem_yumi_i) begin
               yumi_fire_c = 1'b1;
               state_next  = st_resp;
            end
         end
         st_resp: begin
            resp_show_c = bus.mem_resp_valid_i;
            if (bus.mem_resp_valid_i && resp_yumi8[owner_reg]) begin
               resp_fire_c = 1'b1;
               state_next  = st_idle;
               rr_ptr_next = (owner_reg == 3'(num_req_p - 1)) ? 3'd0 : owner_reg + 3'd1;
            end
         end
         default: begin
            state_next = st_idle;
         end
      endcase
      if (!reset) begin
         mem_valid_c = 1'b0;
         yumi_fire_c = 1'b0;
         resp_show_c = 1'b0;
         resp_fire_c = 1'b0;
      end
   end

   // FSM, owner and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= st_idle;
         owner_reg  <= 3'd0;
         rr_ptr_reg <= 3'd0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // Capture the winner's request so later requester activity cannot disturb it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wen_reg   <= 1'b0;
         byte_reg  <= 1'b0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
      end else if (latch_en) begin
         wen_reg   <= wen8[grant_idx];
         byte_reg  <= byte8[grant_idx];
         addr_reg  <= core_addr[grant_idx];
         wdata_reg <= core_wdata[grant_idx];
      end
   end

   assign cnt_inc = {1'b0, cnt_reg} + 9'd1;

   // Busy-cycle counter, restarted per transaction; the flag it raises is sticky.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_reg     <= 8'd0;
         timeout_reg <= 1'b0;
      end else if (latch_en) begin
         cnt_reg <= 8'd0;
      end else if (state_reg != st_idle) begin
         if (cnt_reg != 8'hFF) begin
            cnt_reg <= cnt_inc[7:0];
         end
         if (cnt_inc == 9'(timeout_p)) begin
            timeout_reg <= 1'b1;
         end
      end
   end

   generate
      for (gi = 0; gi < num_req_p; gi++) begin : g_onehot
         assign bus.req_yumi_o[gi]   = yumi_fire_c && (owner_reg == 3'(gi));
         assign bus.resp_valid_o[gi] = resp_show_c && (owner_reg == 3'(gi));
      end
   endgenerate

   assign bus.resp_data_o     = bus.mem_rdata_i;
   assign bus.mem_valid_o     = mem_valid_c;
   assign bus.mem_wen_o       = wen_reg;
   assign bus.mem_byte_o      = byte_reg;
   assign bus.mem_addr_o      = addr_reg;
   assign bus.mem_wdata_o     = wdata_reg;
   assign bus.mem_resp_yumi_o = resp_fire_c;
   assign bus.owner_o         = owner_reg;
   assign bus.busy_o          = (state_reg != st_idle);
   assign bus.timeout_o       = timeout_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus queues expected grants
// and responses; a monitor compares them whenever the DUT handshakes.
module tb_dmem_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.num_req_p(NR)) bus ();

   dmem_arbiter #(.num_req_p(NR), .timeout_p(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          core;
      logic        wen;
      logic        byte_nw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      int          core;
      logic [31:0] data;
   } resp_t;

   grant_t exp_grant[$];
   resp_t  exp_resp[$];
   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: pop and compare on every request accept and every response handshake.
   always @(negedge clk) begin : mon
      grant_t g;
      resp_t  r;
      if (reset) begin
         if (bus.req_yumi_o != '0) begin
            if (exp_grant.size() == 0) begin
               total++;
               bad++;
               $display("FAIL grant_unexpected: got yumi %b required none", bus.req_yumi_o);
            end else begin
               g = exp_grant.pop_front();
               $display("grant core=%0d wen=%0d byte=%0d addr=%h wdata=%h", g.core, g.wen, g.byte_nw, g.addr, g.wdata);
               check("grant_yumi", 32'(bus.req_yumi_o), 32'(1) << g.core);
               check("grant_mem_valid", 32'(bus.mem_valid_o), 32'd1);
               check("grant_addr", bus.mem_addr_o, g.addr);
               check("grant_wen", 32'(bus.mem_wen_o), 32'(g.wen));
               check("grant_byte", 32'(bus.mem_byte_o), 32'(g.byte_nw));
               check("grant_wdata", bus.mem_wdata_o, g.wdata);
               check("grant_owner", 32'(bus.owner_o), 32'(g.core));
            end
         end
         if (bus.mem_resp_yumi_o) begin
            if (exp_resp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL resp_unexpected: got mem_resp_yumi 1 required 0");
            end else begin
               r = exp_resp.pop_front();
               $display("resp  core=%0d data=%h", r.core, r.data);
               check("resp_valid", 32'(bus.resp_valid_o), 32'(1) << r.core);
               check("resp_data", bus.resp_data_o, r.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid_i      = '0;
      bus.req_wen_i        = '0;
      bus.req_byte_i       = '0;
      bus.req_addr_i       = '0;
      bus.req_wdata_i      = '0;
      bus.resp_yumi_i      = '0;
      bus.mem_yumi_i       = 1'b0;
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_rdata_i      = '0;
   endtask

   task automatic set_core(input int k, input logic wen, input logic b,
                           input logic [31:0] a, input logic [31:0] d);
      bus.req_wen_i[k]            = wen;
      bus.req_byte_i[k]           = b;
      bus.req_addr_i[32*k +: 32]  = a;
      bus.req_wdata_i[32*k +: 32] = d;
   endtask

   task automatic push_txn(input int k, input logic wen, input logic b,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
      grant_t g;
      resp_t  r;
      g.core = k; g.wen = wen; g.byte_nw = b; g.addr = a; g.wdata = d;
      r.core = k; r.data = rd;
      exp_grant.push_back(g);
      exp_resp.push_back(r);
   endtask

   // Bounded wait for the scoreboard to drain (grants only, or everything).
   task automatic wait_queues(input bit grants_only, input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound; i++) begin
         done = (exp_grant.size() == 0) && (grants_only || exp_resp.size() == 0);
         if (done) break;
         tick();
      end
      done = (exp_grant.size() == 0) && (grants_only || exp_resp.size() == 0);
      if (!done) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d grants %0d resps pending required 0", exp_grant.size(), exp_resp.size());
         exp_grant.delete();
         exp_resp.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish required finish before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      reset = 1'b0;
      repeat (3) tick();

      // Reset state.
      @(negedge clk);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
      check("rst_req_yumi", 32'(bus.req_yumi_o), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      check("rst_mem_resp_yumi", 32'(bus.mem_resp_yumi_o), 32'd0);
      check("rst_timeout", 32'(bus.timeout_o), 32'd0);
      check("rst_owner", 32'(bus.owner_o), 32'd0);
      check("rst_addr", bus.mem_addr_o, 32'd0);
      tick();

      // Single load by core 2; response offered already in the accept cycle.
      reset = 1'b1;
      set_core(2, 1'b0, 1'b0, 32'h40, 32'h0);
      bus.req_valid_i      = 4'b0100;
      bus.mem_yumi_i       = 1'b1;
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'hDEADBEEF;
      bus.resp_yumi_i      = 4'b0100;
      push_txn(2, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
      tick();
      bus.req_valid_i = '0;
      @(negedge clk);
      check("single_addr", bus.mem_addr_o, 32'h40);
      check("single_yumi", 32'(bus.req_yumi_o), 32'h4);
      check("single_no_early_resp", 32'(bus.mem_resp_yumi_o), 32'd0);
      tick();
      @(negedge clk);
      check("single_resp_valid", 32'(bus.resp_valid_o), 32'h4);
      check("single_resp_data", bus.resp_data_o, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      check("single_busy_after", 32'(bus.busy_o), 32'd0);
      tick();
      idle_inputs();

      // All four cores request continuously from reset: order 0,1,2,3,0.
      reset = 1'b0;
      tick();
      tick();
      for (int k = 0; k < NR; k++) set_core(k, 1'b0, 1'b0, 32'h100 + 32'(4*k), 32'h0);
      for (int n = 0; n < 5; n++) begin
         push_txn(n % NR, 1'b0, 1'b0, 32'h100 + 32'(4*(n % NR)), 32'h0, 32'hA5A50000);
      end
      bus.req_valid_i      = 4'b1111;
      bus.mem_yumi_i       = 1'b1;
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'hA5A50000;
      bus.resp_yumi_i      = 4'b1111;
      reset = 1'b1;
      wait_queues(1'b1, 40);
      bus.req_valid_i = '0;
      wait_queues(1'b0, 10);
      tick();
      idle_inputs();

      // Latch check: core 1 byte store, address changes while memory stalls.
      set_core(1, 1'b1, 1'b1, 32'h10, 32'h55);
      bus.req_valid_i = 4'b0010;
      push_txn(1, 1'b1, 1'b1, 32'h10, 32'h55, 32'h12345678);
      tick();
      bus.req_addr_i[32 +: 32] = 32'h20;
      bus.req_valid_i = '0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check("latch_addr", bus.mem_addr_o, 32'h10);
         check("latch_mem_valid", 32'(bus.mem_valid_o), 32'd1);
         tick();
      end
      bus.mem_yumi_i       = 1'b1;
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'h12345678;
      bus.resp_yumi_i      = 4'b0010;
      wait_queues(1'b0, 10);
      tick();
      @(negedge clk);
      check("latch_no_timeout", 32'(bus.timeout_o), 32'd0);
      tick();
      idle_inputs();

      // Response stall: core 3 withholds resp_yumi for 4 cycles; core 0 yumi ignored.
      set_core(3, 1'b0, 1'b0, 32'h80, 32'h0);
      bus.req_valid_i = 4'b1000;
      bus.mem_yumi_i  = 1'b1;
      push_txn(3, 1'b0, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D);
      tick();
      bus.req_valid_i = '0;
      tick();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'hCAFEF00D;
      bus.resp_yumi_i      = 4'b0001;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         check("stall_mem_resp_yumi", 32'(bus.mem_resp_yumi_o), 32'd0);
         check("stall_resp_valid", 32'(bus.resp_valid_o), 32'h8);
         tick();
      end
      bus.resp_yumi_i = 4'b1001;
      @(negedge clk);
      check("stall_release", 32'(bus.mem_resp_yumi_o), 32'd1);
      tick();
      @(negedge clk);
      check("stall_busy_after", 32'(bus.busy_o), 32'd0);
      tick();
      idle_inputs();

      // Timeout: response withheld past 8 busy cycles, flag survives completion.
      set_core(0, 1'b0, 1'b0, 32'hC0, 32'h0);
      bus.req_valid_i = 4'b0001;
      bus.mem_yumi_i  = 1'b1;
      push_txn(0, 1'b0, 1'b0, 32'hC0, 32'h0, 32'h0BADC0DE);
      tick();
      bus.req_valid_i = '0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         check("timeout_early", 32'(bus.timeout_o), 32'd0);
         tick();
      end
      @(negedge clk);
      check("timeout_set", 32'(bus.timeout_o), 32'd1);
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'h0BADC0DE;
      bus.resp_yumi_i      = 4'b0001;
      tick();
      @(negedge clk);
      check("timeout_sticky", 32'(bus.timeout_o), 32'd1);
      check("timeout_busy_after", 32'(bus.busy_o), 32'd0);
      wait_queues(1'b0, 2);
      tick();
      idle_inputs();

      // Reset during RESP: response dropped, pointer restarts at 0.
      begin
         grant_t g;
         g.core = 2; g.wen = 1'b0; g.byte_nw = 1'b0; g.addr = 32'h44; g.wdata = 32'h0;
         exp_grant.push_back(g);
      end
      set_core(2, 1'b0, 1'b0, 32'h44, 32'h0);
      bus.req_valid_i = 4'b0100;
      bus.mem_yumi_i  = 1'b1;
      tick();
      bus.req_valid_i = '0;
      tick();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'h77777777;
      bus.resp_yumi_i      = 4'b0100;
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_mem_resp_yumi", 32'(bus.mem_resp_yumi_o), 32'd0);
      check("rstmid_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      tick();
      reset = 1'b1;
      set_core(0, 1'b0, 1'b0, 32'h200, 32'h0);
      set_core(1, 1'b0, 1'b0, 32'h204, 32'h0);
      bus.req_valid_i = 4'b0011;
      bus.resp_yumi_i = 4'b1111;
      push_txn(0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h77777777);
      @(negedge clk);
      check("rstmid_busy", 32'(bus.busy_o), 32'd0);
      check("rstmid_mem_valid", 32'(bus.mem_valid_o), 32'd0);
      check("rstmid_req_yumi", 32'(bus.req_yumi_o), 32'd0);
      check("rstmid_idle_resp_yumi", 32'(bus.mem_resp_yumi_o), 32'd0);
      check("rstmid_timeout", 32'(bus.timeout_o), 32'd0);
      check("rstmid_owner", 32'(bus.owner_o), 32'd0);
      tick();
      bus.req_valid_i = '0;
      wait_queues(1'b0, 10);
      tick();
      idle_inputs();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
